// File: rtl/padding.sv
`default_nettype none
// ============================================================================
//  Module      : padding
//  Description : Zero-padding stage for the CNN feature-map path. Takes a
//                flattened INPUT_SIZE x INPUT_SIZE matrix of 4-bit elements
//                and produces an OUTPUT_SIZE x OUTPUT_SIZE matrix with a
//                one-element zero border, copying one interior row per clock
//                under a start/done handshake.
//  Ports       : clk           - rising-edge clock
//                rst           - asynchronous reset, active low (0 = reset)
//                start         - request, held until done is seen
//                input_matrix  - element (r,c) at [(r*INPUT_SIZE+c)*4 +: 4]
//                output_matrix - registered, element (r,c) at
//                                [(r*OUTPUT_SIZE+c)*4 +: 4]
//                done          - registered completion flag
//  Revision    : 1.0 - initial release
// ============================================================================
module padding #(
  parameter int INPUT_SIZE  = 14,
  parameter int OUTPUT_SIZE = INPUT_SIZE + 2,
  parameter int INPUT_BITS  = INPUT_SIZE * INPUT_SIZE * 4,
  parameter int OUTPUT_BITS = OUTPUT_SIZE * OUTPUT_SIZE * 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INPUT_BITS-1:0]  input_matrix,
  output logic [OUTPUT_BITS-1:0] output_matrix,
  output logic                   done
);

  // Row counter needs at least one bit even for a 1x1 input.
  localparam int c_ROW_W    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int c_ROW_BITS = INPUT_SIZE * 4;
  localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(INPUT_SIZE - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_FILL = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  generate
    if (OUTPUT_SIZE != INPUT_SIZE + 2) begin : g_bad_output_size
      $error("padding: OUTPUT_SIZE must equal INPUT_SIZE+2");
    end
  endgenerate

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [c_ROW_W-1:0]     r_row;
  logic [INPUT_BITS-1:0]  r_latch;
  logic [OUTPUT_BITS-1:0] r_out;
  logic                   r_done;

  logic w_last_row;
  logic w_load;
  logic w_fill;
  logic w_done_nxt;

  assign w_last_row = (r_row == c_LAST_ROW);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start)      w_state_nxt = c_FILL;
      c_FILL:  if (w_last_row) w_state_nxt = c_DONE;
      c_DONE:  if (!start)     w_state_nxt = c_IDLE;
      default:                 w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_load     = 1'b0;
    w_fill     = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      c_IDLE: w_load = start;
      c_FILL: begin
        w_fill     = 1'b1;
        w_done_nxt = w_last_row;
      end
      // done stays up only while the requester still holds start.
      c_DONE: w_done_nxt = start;
      default: begin
        w_load     = 1'b0;
        w_fill     = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: input latch, row counter, padded output, done flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_latch <= '0;
      r_out   <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        // Clearing the whole output here establishes the zero border; the
        // border bits are never written again during FILL.
        r_latch <= input_matrix;
        r_out   <= '0;
        r_row   <= '0;
      end else if (w_fill) begin
        for (int r = 0; r < INPUT_SIZE; r++) begin
          if (r_row == c_ROW_W'(r)) begin
            r_out[((r + 1) * OUTPUT_SIZE + 1) * 4 +: c_ROW_BITS] <=
              r_latch[r * c_ROW_BITS +: c_ROW_BITS];
          end
        end
        // Wraps harmlessly after the last row; reloaded on the next start.
        r_row <= r_row + c_ROW_W'(1);
      end
    end
  end

  assign output_matrix = r_out;
  assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_padding.sv
`default_nettype none
// ============================================================================
//  Module      : tb_padding
//  Description : Self-checking bench for padding. Stimulus pushes expected
//                padded matrices into a scoreboard queue; a monitor pops and
//                compares on every rising edge of done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_padding;

  localparam int IS = 14;
  localparam int OS = IS + 2;
  localparam int IB = IS * IS * 4;
  localparam int OB = OS * OS * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IB-1:0] input_matrix;
  logic [OB-1:0] output_matrix;
  logic          done;

  padding #(
    .INPUT_SIZE  (IS),
    .OUTPUT_SIZE (OS),
    .INPUT_BITS  (IB),
    .OUTPUT_BITS (OB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .input_matrix  (input_matrix),
    .output_matrix (output_matrix),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [OB-1:0] sb[$];

  // Reference: every output cell is either border (zero) or the input cell
  // one up and one left of it.
  function automatic logic [OB-1:0] pad_model(input logic [IB-1:0] m);
    logic [OB-1:0] o;
    o = '0;
    for (int r = 0; r < OS; r++) begin
      for (int c = 0; c < OS; c++) begin
        if (r == 0 || r == OS - 1 || c == 0 || c == OS - 1)
          o[(r * OS + c) * 4 +: 4] = 4'h0;
        else
          o[(r * OS + c) * 4 +: 4] = m[((r - 1) * IS + (c - 1)) * 4 +: 4];
      end
    end
    return o;
  endfunction

  function automatic logic [3:0] nib(input logic [OB-1:0] o, input int r, input int c);
    return o[(r * OS + c) * 4 +: 4];
  endfunction

  function automatic int border_nonzero(input logic [OB-1:0] o);
    int n = 0;
    for (int r = 0; r < OS; r++)
      for (int c = 0; c < OS; c++)
        if ((r == 0 || r == OS - 1 || c == 0 || c == OS - 1) && nib(o, r, c) != 4'h0)
          n++;
    return n;
  endfunction

  function automatic int interior_count(input logic [OB-1:0] o, input logic [3:0] v);
    int n = 0;
    for (int r = 1; r < OS - 1; r++)
      for (int c = 1; c < OS - 1; c++)
        if (nib(o, r, c) == v) n++;
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_mat(input string name, input logic [OB-1:0] act, input logic [OB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      for (int k = 0; k < OS * OS; k++) begin
        if (act[k * 4 +: 4] !== exp[k * 4 +: 4]) begin
          $display("FAIL %s: first differing cell (%0d,%0d) got %h, expected %h",
                   name, k / OS, k % OS, act[k * 4 +: 4], exp[k * 4 +: 4]);
          break;
        end
      end
    end
  endtask

  // Monitor: compare result on each rising edge of done.
  logic          prev_done = 1'b0;
  logic [OB-1:0] mon_exp;
  always @(negedge clk) begin
    if (!rst) begin
      prev_done = 1'b0;
    end else begin
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_exp = sb.pop_front();
          chk_mat("result", output_matrix, mon_exp);
        end
      end
      prev_done = done;
    end
  end

  function automatic logic [IB-1:0] rand_matrix();
    logic [IB-1:0] m;
    for (int k = 0; k < IS * IS; k++) m[k * 4 +: 4] = 4'($urandom_range(0, 15));
    return m;
  endfunction

  // Called just after a rising edge; returns just after a rising edge with
  // start low, so a following call gives exactly one low cycle in between.
  task automatic run_op(input logic [IB-1:0] m, input bit corrupt, input int hold,
                        output logic [OB-1:0] expo);
    int edges;
    bit seen;
    input_matrix = m;
    start        = 1'b1;
    expo         = pad_model(m);
    sb.push_back(expo);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (corrupt && edges == 2) input_matrix = {(IB / 4){4'h5}};
      if (done) seen = 1'b1;
    end
    chk("done_latency", edges, IS + 1);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("done_held", int'(done), 1);
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_fall", int'(done), 0);
    chk_mat("hold_after_done", output_matrix, expo);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [IB-1:0] m;
  logic [OB-1:0] e;

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    input_matrix = '0;

    // 1. Reset and idle.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("reset_done", int'(done), 0);
    chk_mat("reset_out", output_matrix, '0);
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_done", int'(done), 0);
      chk_mat("idle_out", output_matrix, '0);
    end

    // 2. Counting pattern.
    for (int k = 0; k < IS * IS; k++) m[k * 4 +: 4] = 4'(k);
    run_op(m, 1'b0, 0, e);
    chk("nib_1_1", int'(nib(output_matrix, 1, 1)), 0);
    chk("nib_1_14", int'(nib(output_matrix, 1, 14)), 13);
    chk("nib_14_14", int'(nib(output_matrix, 14, 14)), 3);
    chk("border_count", border_nonzero(output_matrix), 0);

    // 3. All 0xF, done held while start stays high.
    m = {(IB / 4){4'hF}};
    run_op(m, 1'b0, 3, e);
    chk("interior_f", interior_count(output_matrix, 4'hF), IS * IS);
    chk("border_f", border_nonzero(output_matrix), 0);

    // 4. Input changes after the latch edge are ignored.
    m = rand_matrix();
    run_op(m, 1'b1, 1, e);

    // 5. Reset in the middle of FILL.
    m            = rand_matrix();
    input_matrix = m;
    start        = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_mat("midfill_reset_out", output_matrix, '0);
    chk("midfill_reset_done", int'(done), 0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    m = rand_matrix();
    run_op(m, 1'b0, 0, e);

    // 6. Back-to-back operations with random data and hold times.
    for (int i = 0; i < 6; i++) begin
      m = rand_matrix();
      run_op(m, 1'b0, int'($urandom_range(0, 3)), e);
      chk("b2b_border", border_nonzero(output_matrix), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/padding.md
Name: padding

Overview:
Zero-padding stage for the CNN feature-map path. It takes a flattened INPUT_SIZE x INPUT_SIZE matrix of 4-bit elements and produces an OUTPUT_SIZE x OUTPUT_SIZE matrix with a one-element zero border. It sits before a 3x3 convolution so the convolution output keeps the input dimensions. Operation is a start/done handshake: the block copies the interior one row per clock.

Parameters:
INPUT_SIZE, 14, input matrix side length (rows = cols); legal range 1..64.
OUTPUT_SIZE, INPUT_SIZE+2, output side length; must equal INPUT_SIZE+2.
INPUT_BITS, INPUT_SIZE*INPUT_SIZE*4, width of the flattened input bus.
OUTPUT_BITS, OUTPUT_SIZE*OUTPUT_SIZE*4, width of the flattened output bus.
Element width is fixed at 4 bits and is not a parameter.

Ports:
clk  input  1  rising-edge clock; the block's only clock.
rst  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request; held high by the requester until done is seen.
input_matrix  input  INPUT_BITS  element (r,c) at bits [(r*INPUT_SIZE+c)*4 +: 4].
output_matrix  output  OUTPUT_BITS  registered; element (r,c) at bits [(r*OUTPUT_SIZE+c)*4 +: 4].
done  output  1  registered completion flag.

Behaviour:
- Reset (rst=0, asynchronous, any state): state=IDLE, output_matrix=0, done=0, row counter=0, input latch=0.
- FSM has three states: IDLE, FILL and DONE.
- IDLE: done=0 and output_matrix holds its last value. When start=1 at a clock edge:
  - latch input_matrix into an internal register;
  - clear output_matrix to all zeros;
  - set row=0 and go to FILL.
- FILL, one input row per clock edge:
  - write latched row r to output row r+1, columns 1..INPUT_SIZE;
  - increment row.
- Leaving FILL: on the edge that writes row INPUT_SIZE-1, go to DONE and set done=1.
- Latency: start is sampled at edge N. Rows are written on edges N+1..N+INPUT_SIZE, and done is high after edge N+INPUT_SIZE (15 edges total for 14x14). output_matrix is final once done=1.
- DONE: done=1 and output_matrix is stable.
  - start=1: stay in DONE.
  - start=0 at an edge: clear done and return to IDLE. output_matrix keeps its result until the next start.
- Border cells are always 0:
  - output row 0 and row OUTPUT_SIZE-1;
  - column 0 and column OUTPUT_SIZE-1 of every row.
- Interior mapping: output(r+1,c+1) = input(r,c) for 0<=r,c<INPUT_SIZE, bit-exact with no arithmetic.
- start is only sampled in IDLE and DONE. Deasserting start during FILL does not abort the operation. Changes on input_matrix after the latch edge are ignored.
- If start is low by the time DONE is reached, done is high for exactly one cycle.
- Back-to-back: start held high through DONE does not restart. A new operation requires start=0, a return to IDLE, then start=1 again.
- Reset asserted mid-FILL or in DONE immediately clears all outputs. Operation resumes in IDLE after rst returns to 1.
- INPUT_SIZE=1 gives a 3x3 output with one FILL cycle.

Test Plan:
1. Apply rst=0 for 2 cycles, then release -> output_matrix=0 and done=0. Hold start=0 for 10 cycles -> outputs stay 0.
2. Load 14x14 input with nibble k = k mod 16, then pulse start=1 held until done -> done rises exactly 15 edges after start is sampled. Then:
   - output(1,1)=0x0, output(1,14)=0xD, output(14,14)=input nibble 195 = 0x3;
   - all 60 border nibbles = 0.
3. Input all 0xF -> output has 196 interior nibbles = 0xF and 60 border nibbles = 0. done stays 1 while start=1, then falls one edge after start=0.
4. Start a run, then change input_matrix to all 0x5 two cycles after start -> output equals the originally latched input, not 0x5.
5. Drive rst=0 mid-FILL at row 7 -> output_matrix=0 and done=0 immediately. Restart with start -> correct full result in 15 edges.
6. Run two operations back to back (start low for 1 cycle between) with different inputs -> the second result fully replaces the first, and its border is still 0.
